// File: rtl/parity_frame_pkg.sv
// Shared types and defaults for the even-parity frame controller.
package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_CNT_W     = 8;

    // Bit-counter width; a one-bit word still needs a one-bit counter.
    function automatic int bit_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/even_parity_tracker.sv
// One-bit running parity of the bits fed through en; odd=1 means an odd count of ones.
module even_parity_tracker (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic odd
);

    logic odd_q;
    logic odd_d;

    // Next odd flag: clear wins over a feed.
    always_comb begin
        odd_d = odd_q;
        if (clear) begin
            odd_d = 1'b0;
        end else if (en && bit_in) begin
            odd_d = ~odd_q;
        end else begin
            odd_d = odd_q;
        end
    end

    // Odd flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            odd_q <= 1'b0;
        end else begin
            odd_q <= odd_d;
        end
    end

    assign odd = odd_q;

endmodule

// File: rtl/parity_frame_controller.sv
// Serial even-parity frame receiver with valid/ack output hold and overrun detection.
// Optional saturating error counter enabled by defining PARITY_ERR_COUNT_EN.
module parity_frame_controller
    import parity_frame_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
`ifdef PARITY_ERR_COUNT_EN
    , parameter int CNT_W   = DEF_CNT_W
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_en,
    input  logic                 rx_bit,
    input  logic                 frame_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef PARITY_ERR_COUNT_EN
    , output logic [CNT_W-1:0]   err_count
`endif
);

    localparam int CW = bit_cnt_width(DATA_BITS);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d, shift_next_s;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  busy_q, busy_d;
    logic                  trk_clear_s, trk_en_s, trk_odd_s;
    logic                  complete_s, accept_s;

    even_parity_tracker u_tracker (
        .clk    (clk),
        .reset  (reset),
        .clear  (trk_clear_s),
        .en     (trk_en_s),
        .bit_in (rx_bit),
        .odd    (trk_odd_s)
    );

    // LSB-first: new bits enter at the top so the first bit ends in bit 0.
    generate
        if (DATA_BITS > 1) begin : g_shift_wide
            assign shift_next_s = {rx_bit, shift_q[DATA_BITS-1:1]};
        end else begin : g_shift_one
            assign shift_next_s = rx_bit;
        end
    endgenerate

    // Next-state, shift, tracker control and output-hold logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        ovr_d       = ovr_q;
        trk_clear_s = 1'b0;
        trk_en_s    = 1'b0;
        complete_s  = 1'b0;

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_bit) begin
                        state_d     = DATA;
                        cnt_d       = {CW{1'b0}};
                        trk_clear_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    shift_d  = shift_next_s;
                    trk_en_s = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = PARITY;
                    end else begin
                        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    trk_en_s = 1'b1;
                    state_d  = STOP;
                end
                STOP: begin
                    complete_s = 1'b1;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // A completing frame is accepted when the slot is free or freed on this edge.
        accept_s = complete_s && (!valid_q || frame_ack);

        if (accept_s) begin
            data_d  = shift_q;
            perr_d  = trk_odd_s;
            ferr_d  = ~rx_bit;
            valid_d = 1'b1;
            ovr_d   = 1'b0;
        end else if (complete_s) begin
            ovr_d = 1'b1;
        end else if (frame_ack && valid_q) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            shift_q <= {DATA_BITS{1'b0}};
            data_q  <= {DATA_BITS{1'b0}};
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out    = data_q;
    assign frame_valid = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = busy_q;

`ifdef PARITY_ERR_COUNT_EN
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] err_q, err_d;

    // Count accepted frames carrying any error; dropped frames never count.
    always_comb begin
        err_d = err_q;
        if (accept_s && (trk_odd_s || !rx_bit) && (err_q != ERR_MAX)) begin
            err_d = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_d = err_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= {CNT_W{1'b0}};
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_parity_frame_controller.sv
// Scoreboard bench: stimulus pushes expected output snapshots, a monitor pops on every change.
module tb_parity_frame_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_en = 1'b0;
    logic       rx_bit = 1'b1;
    logic       frame_ack = 1'b0;
    logic [7:0] data_out;
    logic       frame_valid, parity_err, frame_err, overrun, busy;
`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic       v;
        logic       o;
        logic       p;
        logic       f;
        logic [7:0] d;
    } snap_t;

    snap_t exp_q[$];
    snap_t prev_snap = '0;

    parity_frame_controller dut (
        .clk         (clk),
        .reset       (reset),
        .bit_en      (bit_en),
        .rx_bit      (rx_bit),
        .frame_ack   (frame_ack),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
`ifdef PARITY_ERR_COUNT_EN
        , .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input logic v, input logic o, input logic p,
                                 input logic f, input logic [7:0] d);
        snap_t s;
        s.v = v; s.o = o; s.p = p; s.f = f; s.d = d;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any change of the visible output set consumes one expected snapshot.
    always @(negedge clk) begin
        snap_t cur;
        cur = mk(frame_valid, overrun, parity_err, frame_err, data_out);
        if (cur !== prev_snap) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got v=%b o=%b p=%b f=%b d=0x%0h, none expected at %0t",
                         cur.v, cur.o, cur.p, cur.f, cur.d, $time);
            end else begin
                snap_t e;
                e = exp_q.pop_front();
                if (cur === e) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL sb_snapshot: got v=%b o=%b p=%b f=%b d=0x%0h expected v=%b o=%b p=%b f=%b d=0x%0h at %0t",
                             cur.v, cur.o, cur.p, cur.f, cur.d, e.v, e.o, e.p, e.f, e.d, $time);
                end
            end
            prev_snap = cur;
        end
    end

    task automatic idle_cycles(input int n);
        bit_en = 1'b0;
        frame_ack = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic ack);
        rx_bit = b;
        bit_en = 1'b1;
        frame_ack = ack;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic ack_stop, input int gap, input logic fresh);
        send_bit(1'b0, 1'b0);
        check("busy_after_start", busy, 1);
        idle_cycles(gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], 1'b0);
            idle_cycles(gap);
        end
        send_bit(p, 1'b0);
        idle_cycles(gap);
        check("busy_before_stop", busy, 1);
        if (fresh) begin
            check("valid_before_stop", frame_valid, 0);
        end
        send_bit(s, ack_stop);
        check("busy_after_stop", busy, 0);
        check("valid_after_stop", frame_valid, 1);
        rx_bit = 1'b1;
        idle_cycles(gap);
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        check("valid_after_ack", frame_valid, 0);
        check("overrun_after_ack", overrun, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data_out, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        reset = 1'b0;
        idle_cycles(2);

        // Clean frame 0xA5 (four ones, parity 0)
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5));
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5));
        ack_frame();

        // Parity error: 0x01 with parity 0
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h01));
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b1);
`ifdef PARITY_ERR_COUNT_EN
        check("err_count_1", err_count, 1);
`endif
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h01));
        ack_frame();

        // Framing error: 0x3C, stop bit 0
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h3C));
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b1);
`ifdef PARITY_ERR_COUNT_EN
        check("err_count_2", err_count, 2);
`endif
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C));
        ack_frame();

        // Overrun: 0x11 held, 0x22 dropped
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h11));
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h11));
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        check("overrun_set", overrun, 1);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h11));
        ack_frame();

        // Ack on the completion edge replaces the held frame and clears overrun
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h44));
        send_frame(8'h44, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h44));
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h33));
        send_frame(8'h33, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h33));
        ack_frame();
`ifdef PARITY_ERR_COUNT_EN
        check("err_count_no_drop", err_count, 2);
`endif

        // Reset mid-frame during 4th data bit of 0xFF, with a held frame present
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A));
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 1'b0);
        end
        rx_bit = 1'b1;
        bit_en = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_valid", frame_valid, 0);
        check("async_rst_data", data_out, 0);
        check("async_rst_busy", busy, 0);
        bit_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
`ifdef PARITY_ERR_COUNT_EN
        check("err_count_rst", err_count, 0);
`endif
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C));
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C));
        ack_frame();

        // Strobe every third cycle: 0x80 with parity 1
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h80));
        send_frame(8'h80, 1'b1, 1'b1, 1'b0, 2, 1'b1);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h80));
        ack_frame();

        idle_cycles(4);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/parity_frame_controller.md
# parity_frame_controller

Sequencing controller for serial even-parity reception. It detects a start bit, shifts in a fixed-width data word, and runs the received parity bit through an even-parity tracker. It then checks the stop bit and presents the word with error flags on a valid/ack handshake. It sits between a bit-strobed serial line and any consumer that needs checked words rather than a raw parity-error line.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame (≥1), LSB first
- CNT_W, 8, width of error counter (only with macro)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs
- bit_en  in  1  bit strobe; rx_bit is sampled only on edges where bit_en=1
- rx_bit  in  1  serial line; idle level 1
- frame_ack  in  1  consumer accepts the held frame
- data_out  out  DATA_BITS  received word; valid while frame_valid=1
- frame_valid  out  1  frame held for consumer
- parity_err  out  1  ones count over data+parity is odd
- frame_err  out  1  stop bit sampled as 0
- overrun  out  1  a frame completed while the previous one was unacknowledged
- busy  out  1  state ≠ IDLE
- err_count  out  CNT_W  saturating count of frames with parity_err or frame_err (macro only)

## Operation
- States: IDLE, DATA, PARITY, STOP. Transitions occur only on edges with bit_en=1. With bit_en=0, state, counter, shift register and tracker all hold.
- IDLE: rx_bit=0 is the start bit. It clears the parity tracker and bit counter, then moves to DATA. rx_bit=1 stays in IDLE.
- DATA: shifts rx_bit into the shift register (LSB first) and feeds it to the tracker. The counter increments from 0 and wraps to 0. When the counter reaches DATA_BITS-1, the state moves to PARITY.
- PARITY: feeds rx_bit to the tracker, then moves to STOP.
- STOP: samples the stop bit and completes the frame, then moves to IDLE. There is no return to IDLE from DATA or PARITY except through reset.
- Frame completion:
  - If frame_valid=0, or frame_ack=1 on the same edge: load data_out, parity_err = tracker odd flag, frame_err = ~rx_bit, and set frame_valid=1.
  - Otherwise: drop the new frame, keep the held frame and flags, and set overrun=1.
- frame_ack with frame_valid=1 and no completion on that edge: clears frame_valid, parity_err, frame_err and overrun. data_out keeps its value.
- frame_ack with frame_valid=0 is ignored.
- Overrun is sticky until the next accepted ack.
- Parity rule: even parity. The XOR of all data bits and the parity bit must be 0.

## Timing
- All outputs are registered.
- Reset value: data_out=0; frame_valid, parity_err, frame_err, overrun, busy = 0; err_count=0.
- With bit_en held at 1, the start bit is sampled at edge 0, data at edges 1..DATA_BITS, parity at edge DATA_BITS+1, and stop at edge DATA_BITS+2.
- frame_valid is visible after edge DATA_BITS+2 (edge 10 for DATA_BITS=8).
- The earliest next start bit can be sampled at edge DATA_BITS+3.
- busy rises after the start-bit edge and falls after the stop-bit edge.
- Reset asserted mid-frame takes effect immediately and asynchronously. The partial frame is discarded. The first edge after deassertion is evaluated in IDLE.

## Configuration
- PARITY_ERR_COUNT_EN defined:
  - err_count increments by 1 at each accepted frame completion with parity or framing error.
  - It saturates at 2^CNT_W-1.
  - It is cleared only by reset.
  - Dropped (overrun) frames are not counted.
- PARITY_ERR_COUNT_EN undefined: the err_count port and its logic are absent. All other behaviour is identical.

## Structure
- Package parity_frame_pkg holds:
  - the state enum typedef (IDLE, DATA, PARITY, STOP)
  - the default DATA_BITS and CNT_W constants
- Sub-module even_parity_tracker holds a one-bit odd flag.
  - Ports: clk, reset, clear, en, bit_in, odd.
  - clear has priority over en.
  - en toggles odd when bit_in=1.

## Test plan
- Frame 0xA5, parity 0, stop 1, bit_en=1 → after edge 10: data_out=0xA5, frame_valid=1, parity_err=0, frame_err=0.
- Frame 0x01, parity 0, stop 1 → parity_err=1, data_out=0x01. With macro: err_count=1.
- Frame 0x3C, parity 0, stop 0 → frame_err=1, parity_err=0.
- Two frames 0x11 and 0x22, no ack → data_out stays 0x11 and overrun=1 after the second stop. Ack → frame_valid=0, overrun=0. Ack coinciding with the second completion → data_out=0x22 and overrun=0.
- Reset pulsed during the 4th data bit of 0xFF → all outputs 0 and busy=0 immediately. A following frame 0x3C (parity 0) is received correctly.
- bit_en=1 every third cycle, frame 0x80 with parity 1 → data_out=0x80, parity_err=0. State holds on non-strobe edges, and frame_valid is set on the stop-bit strobe edge.
